// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among N producers.
// Grants one owner at a time for bursts of up to MaxBurst words, stalling on FIFO full.
module fifo_wr_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned MaxBurst  = 4
) (
  input  logic                           clk_i,
  input  logic                           res_ni,
  input  logic [N-1:0]                   req_i,
  input  logic [N*DataWidth-1:0]         din_i,
  output logic [N-1:0]                   ack_o,
  input  logic                           fifo_full_i,
  output logic                           fifo_push_o,
  output logic [DataWidth-1:0]           fifo_din_o,
  output logic                           busy_o,
  output logic [$clog2(N)-1:0]           owner_o
);

  localparam int unsigned OwnerW = $clog2(N);
  localparam int unsigned BcntW  = $clog2(MaxBurst + 1);

  logic              busy_q, busy_d;
  logic [OwnerW-1:0] owner_q, owner_d;
  logic [OwnerW-1:0] ptr_q, ptr_d;
  logic [BcntW-1:0]  bcnt_q, bcnt_d;
  logic [OwnerW-1:0] ptr_next;
  logic              push;
  logic              release_own;

  // First requesting index at or above start, wrapping modulo N.
  function automatic logic [OwnerW-1:0] pick(input logic [N-1:0]      r,
                                            input logic [OwnerW-1:0] start);
    logic [OwnerW-1:0] idx;
    logic [OwnerW-1:0] sel;
    logic              found;
    idx   = start;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
      idx = (idx == OwnerW'(N - 1)) ? '0 : idx + 1'b1;
    end
    return sel;
  endfunction

  // Push is gated by reset so an abandoned burst never writes during the reset cycle.
  assign push        = res_ni & busy_q & req_i[owner_q] & ~fifo_full_i;
  assign release_own = busy_q & (~req_i[owner_q] | (push & (bcnt_q == BcntW'(MaxBurst - 1))));
  assign ptr_next    = (owner_q == OwnerW'(N - 1)) ? '0 : owner_q + 1'b1;

  assign fifo_push_o = push;
  assign fifo_din_o  = din_i[DataWidth*owner_q +: DataWidth];
  assign busy_o      = busy_q;
  assign owner_o     = owner_q;

  always_comb begin
    ack_o = '0;
    if (push) begin
      ack_o[owner_q] = 1'b1;
    end
  end

  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    if (!busy_q) begin
      if (|req_i) begin
        busy_d  = 1'b1;
        owner_d = pick(req_i, ptr_q);
        bcnt_d  = '0;
      end
    end else if (release_own) begin
      // Re-arbitrate at the release edge so the next burst starts without a bubble.
      ptr_d  = ptr_next;
      bcnt_d = '0;
      if (|req_i) begin
        owner_d = pick(req_i, ptr_next);
      end else begin
        busy_d  = 1'b0;
        owner_d = '0;
      end
    end else if (push) begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!res_ni) begin
      busy_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: two instances (burst 4 and burst 1) on shared stimulus,
// checked every cycle against a behavioural arbitration model plus directed scenarios.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;

  logic                 clk;
  logic                 res_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*8-1:0]    din;
  logic                 full;

  logic [1:0][NREQ-1:0] ack_w;
  logic [1:0]           push_w;
  logic [1:0][7:0]      fdin_w;
  logic [1:0]           busy_w;
  logic [1:0][1:0]      owner_w;
  logic [1:0][1:0]      ptr_w;
  logic [1:0][2:0]      bcnt_w;

  fifo_wr_arbiter #(.N(4), .DataWidth(8), .MaxBurst(4)) dut_a (
    .clk_i       (clk),
    .res_ni      (res_n),
    .req_i       (req),
    .din_i       (din),
    .ack_o       (ack_w[0]),
    .fifo_full_i (full),
    .fifo_push_o (push_w[0]),
    .fifo_din_o  (fdin_w[0]),
    .busy_o      (busy_w[0]),
    .owner_o     (owner_w[0])
  );

  fifo_wr_arbiter #(.N(4), .DataWidth(8), .MaxBurst(1)) dut_b (
    .clk_i       (clk),
    .res_ni      (res_n),
    .req_i       (req),
    .din_i       (din),
    .ack_o       (ack_w[1]),
    .fifo_full_i (full),
    .fifo_push_o (push_w[1]),
    .fifo_din_o  (fdin_w[1]),
    .busy_o      (busy_w[1]),
    .owner_o     (owner_w[1])
  );

  assign ptr_w[0]  = dut_a.ptr_q;
  assign ptr_w[1]  = dut_b.ptr_q;
  assign bcnt_w[0] = dut_a.bcnt_q;
  assign bcnt_w[1] = {2'b00, dut_b.bcnt_q};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, index 0 = burst-4 instance, 1 = burst-1 instance.
  int m_busy[2];
  int m_owner[2];
  int m_ptr[2];
  int m_bcnt[2];
  int mb[2] = '{4, 1};

  logic [7:0] word[NREQ];
  logic [3:0] ack_seen;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [3:0] v, input int i);
    return ((v >> i) & 4'd1) == 4'd1;
  endfunction

  function automatic logic [7:0] slice_of(input logic [31:0] v, input int i);
    logic [31:0] t;
    t = v >> (8 * i);
    return t[7:0];
  endfunction

  function automatic int first_req(input logic [3:0] r, input int from);
    for (int k = 0; k < NREQ; k++) begin
      if (bit_of(r, (from + k) % NREQ)) return (from + k) % NREQ;
    end
    return 0;
  endfunction

  function automatic bit exp_push(input int m);
    return (res_n == 1'b1) && (m_busy[m] != 0) && bit_of(req, m_owner[m]) && (full == 1'b0);
  endfunction

  function automatic string tg(input int m, input string name);
    return $sformatf("%s_%s", (m == 0) ? "a" : "b", name);
  endfunction

  task automatic model_update();
    bit p;
    bit rel;
    for (int m = 0; m < 2; m++) begin
      if (res_n !== 1'b1) begin
        m_busy[m] = 0; m_owner[m] = 0; m_ptr[m] = 0; m_bcnt[m] = 0;
      end else if (m_busy[m] == 0) begin
        if (req != 4'd0) begin
          m_owner[m] = first_req(req, m_ptr[m]);
          m_busy[m]  = 1;
          m_bcnt[m]  = 0;
        end
      end else begin
        p   = exp_push(m);
        rel = !bit_of(req, m_owner[m]) || (p && (m_bcnt[m] == mb[m] - 1));
        if (p) m_bcnt[m]++;
        if (rel) begin
          m_ptr[m]  = (m_owner[m] + 1) % NREQ;
          m_bcnt[m] = 0;
          if (req != 4'd0) begin
            m_owner[m] = first_req(req, m_ptr[m]);
          end else begin
            m_busy[m]  = 0;
            m_owner[m] = 0;
          end
        end
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge,
  // then present the next word of every requester the model says was acked.
  task automatic tick();
    bit         ep;
    logic [7:0] ed;
    logic [3:0] ea;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      ep = exp_push(m);
      ed = slice_of(din, m_owner[m]);
      ea = ep ? (4'd1 << m_owner[m]) : 4'd0;
      check_eq(tg(m, "push"), 32'(push_w[m]), 32'(ep));
      check_eq(tg(m, "ack"), 32'(ack_w[m]), 32'(ea));
      check_eq(tg(m, "din"), 32'(fdin_w[m]), 32'(ed));
      check_eq(tg(m, "busy"), 32'(busy_w[m]), 32'(m_busy[m]));
      check_eq(tg(m, "owner"), 32'(owner_w[m]), 32'(m_owner[m]));
      check_eq(tg(m, "ptr"), 32'(ptr_w[m]), 32'(m_ptr[m]));
      if (m_busy[m] != 0) check_eq(tg(m, "bcnt"), 32'(bcnt_w[m]), 32'(m_bcnt[m]));
      if (m == 0) begin
        ack_seen = ea;
        if (ep) exp_q.push_back(ed);
        if (push_w[0] === 1'b1) got_q.push_back(fdin_w[0]);
      end
    end
    @(posedge clk);
    model_update();
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (bit_of(ack_seen, i)) word[i] = word[i] + 8'd1;
    end
    din = {word[3], word[2], word[1], word[0]};
  endtask

  initial begin
    int         o0;
    logic [3:0] nreq;
    res_n = 1'b0;
    req   = 4'b0000;
    full  = 1'b0;
    for (int i = 0; i < NREQ; i++) word[i] = 8'hA0 + 8'(i);
    din = {word[3], word[2], word[1], word[0]};
    @(posedge clk);
    model_update();
    #1;

    // Reset held with every requester asking.
    req = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      #1;
      check_eq("rst_push", 32'(push_w[0]), 32'd0);
      check_eq("rst_ack", 32'(ack_w[0]), 32'd0);
      tick();
      check_eq("rst_busy", 32'(busy_w[0]), 32'd0);
      check_eq("rst_owner", 32'(owner_w[0]), 32'd0);
    end
    res_n = 1'b1;
    tick();
    check_eq("rst_first_grant", 32'(owner_w[0]), 32'd0);
    check_eq("rst_first_busy", 32'(busy_w[0]), 32'd1);

    // Single requester: burst of 4, immediate regrant to the same owner.
    req = 4'b0000;
    tick();
    word[2] = 8'h20;
    din = {word[3], word[2], word[1], word[0]};
    req = 4'b0100;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("single_push", 32'(push_w[0]), 32'd1);
      check_eq("single_data", 32'(fdin_w[0]), 32'h20 + 32'(i));
      check_eq("single_owner", 32'(owner_w[0]), 32'd2);
      tick();
      if (i == 3) check_eq("single_ptr", 32'(ptr_w[0]), 32'd3);
    end

    // Round robin with burst 1: one push per cycle, owner advancing by one.
    req = 4'b0000;
    tick();
    req = 4'b1111;
    tick();
    o0 = m_owner[1];
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq("rr_push", 32'(push_w[1]), 32'd1);
      check_eq("rr_owner", 32'(owner_w[1]), 32'((o0 + i) % NREQ));
      tick();
    end

    // Full stall on owner 1 at bcnt 2, then two more words and handoff to 3.
    req = 4'b0000;
    tick();
    req = 4'b0010;
    tick();
    tick();
    tick();
    req  = 4'b1011;
    full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("full_push", 32'(push_w[0]), 32'd0);
      check_eq("full_owner", 32'(owner_w[0]), 32'd1);
      check_eq("full_bcnt", 32'(bcnt_w[0]), 32'd2);
      tick();
    end
    full = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("resume_ack", 32'(ack_w[0]), 32'b0010);
      tick();
    end
    check_eq("full_handoff", 32'(owner_w[0]), 32'd3);

    // Early release of owner 0 after two words hands over to 3.
    req = 4'b0000;
    tick();
    req = 4'b0001;
    tick();
    req = 4'b1001;
    tick();
    tick();
    req = 4'b1000;
    #1;
    check_eq("early_nopush", 32'(push_w[0]), 32'd0);
    tick();
    check_eq("early_owner", 32'(owner_w[0]), 32'd3);
    check_eq("early_ptr", 32'(ptr_w[0]), 32'd1);
    #1;
    check_eq("early_ack", 32'(ack_w[0]), 32'b1000);
    tick();

    // Reset in the middle of owner 2's burst.
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    tick();
    res_n = 1'b0;
    #1;
    check_eq("midrst_push", 32'(push_w[0]), 32'd0);
    tick();
    check_eq("midrst_busy", 32'(busy_w[0]), 32'd0);
    res_n = 1'b1;

    // Randomized traffic with back-pressure, withdrawals and occasional reset.
    for (int c = 0; c < 1500; c++) begin
      nreq = 4'b0000;
      for (int i = 0; i < NREQ; i++) begin
        if (bit_of(req, i) && !bit_of(ack_seen, i)) begin
          if ($urandom_range(0, 9) != 0) nreq = nreq | (4'd1 << i);
        end else if ($urandom_range(0, 1) == 1) begin
          nreq = nreq | (4'd1 << i);
        end
      end
      req   = nreq;
      full  = ($urandom_range(0, 3) == 0);
      res_n = ($urandom_range(0, 99) != 0);
      tick();
    end

    check_eq("sb_len", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) check_eq("sb_word", 32'(got_q[i]), 32'(exp_q[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
